// File: rtl/npc_mem_pkg.sv
// Shared definitions for the memory-port arbitration path.
//   ADDR_W_DEF / DATA_W_DEF : default address / data widths
//   state_e                 : arbiter FSM states
//   owner_e                 : which requester owns the outstanding transaction
package npc_mem_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 64;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IFU,
    OWN_LSU
  } owner_e;

  // Grant index 0 is the IFU, index 1 is the LSU.
  localparam int unsigned GNT_IFU = 0;
  localparam int unsigned GNT_LSU = 1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker.
//   req        : request vector, bit 0 = requester 0, bit 1 = requester 1
//   last_grant : 0 = requester 0 was granted last, 1 = requester 1 was granted last
//   grant      : one-hot grant (all zero when nothing requests)
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      // Tie: the requester that was not served last wins.
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one handshaked memory port between the instruction-fetch unit (read-only)
// and the load/store unit (read/write). One transaction is outstanding at a time;
// ties are broken round-robin.
//   clock, reset        : clock, asynchronous active-high reset
//   ifu_req_* / ifu_resp_* : IFU read request / response handshakes
//   lsu_req_* / lsu_resp_* : LSU read/write request / response handshakes
//   mem_req_* / mem_resp_* : downstream memory request / response handshakes
module mem_port_arbiter
  import npc_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned MASK_W = DATA_W / 8
) (
  input  logic              clock,
  input  logic              reset,

  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_req_addr,
  output logic              ifu_resp_valid,
  input  logic              ifu_resp_ready,
  output logic [DATA_W-1:0] ifu_resp_data,

  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [ADDR_W-1:0] lsu_req_addr,
  input  logic              lsu_req_wen,
  input  logic [DATA_W-1:0] lsu_req_wdata,
  input  logic [MASK_W-1:0] lsu_req_wmask,
  output logic              lsu_resp_valid,
  input  logic              lsu_resp_ready,
  output logic [DATA_W-1:0] lsu_resp_data,

  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_wen,
  output logic [DATA_W-1:0] mem_req_wdata,
  output logic [MASK_W-1:0] mem_req_wmask,
  input  logic              mem_resp_valid,
  output logic              mem_resp_ready,
  input  logic [DATA_W-1:0] mem_resp_data
);

  state_e            state_q;
  owner_e            owner_q;
  logic              last_lsu_q;  // 1: LSU was granted last
  logic [ADDR_W-1:0] addr_q;
  logic              wen_q;
  logic [DATA_W-1:0] wdata_q;
  logic [MASK_W-1:0] wmask_q;
  logic [DATA_W-1:0] rdata_q;

  logic [1:0] grant;
  logic       ifu_hs;
  logic       lsu_hs;
  logic       resp_hs;

  rr_arb2 u_rr_arb2 (
    .req        ({lsu_req_valid, ifu_req_valid}),
    .last_grant (last_lsu_q),
    .grant      (grant)
  );

  // Requests are only offered readiness while idle; grant is already gated by valid.
  assign ifu_req_ready = (state_q == IDLE) && grant[GNT_IFU];
  assign lsu_req_ready = (state_q == IDLE) && grant[GNT_LSU];
  assign ifu_hs        = ifu_req_valid && ifu_req_ready;
  assign lsu_hs        = lsu_req_valid && lsu_req_ready;

  // Downstream request is driven purely from the latched fields.
  assign mem_req_valid  = (state_q == ISSUE);
  assign mem_req_addr   = addr_q;
  assign mem_req_wen    = wen_q;
  assign mem_req_wdata  = wdata_q;
  assign mem_req_wmask  = wmask_q;
  assign mem_resp_ready = (state_q == WAIT);

  assign ifu_resp_valid = (state_q == RESP) && (owner_q == OWN_IFU);
  assign lsu_resp_valid = (state_q == RESP) && (owner_q == OWN_LSU);
  assign ifu_resp_data  = rdata_q;
  assign lsu_resp_data  = rdata_q;

  assign resp_hs = (ifu_resp_valid && ifu_resp_ready) || (lsu_resp_valid && lsu_resp_ready);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= OWN_NONE;
      last_lsu_q <= 1'b1;
      addr_q     <= '0;
      wen_q      <= 1'b0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      rdata_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ifu_hs || lsu_hs) begin
            // IFU fetches are reads: write enable and mask are forced low.
            addr_q     <= lsu_hs ? lsu_req_addr : ifu_req_addr;
            wen_q      <= lsu_hs && lsu_req_wen;
            wdata_q    <= lsu_hs ? lsu_req_wdata : '0;
            wmask_q    <= lsu_hs ? lsu_req_wmask : '0;
            owner_q    <= lsu_hs ? OWN_LSU : OWN_IFU;
            last_lsu_q <= lsu_hs;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_req_ready) begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (mem_resp_valid) begin
            rdata_q <= mem_resp_data;
            state_q <= RESP;
          end
        end
        RESP: begin
          if (resp_hs) begin
            owner_q <= OWN_NONE;
            state_q <= IDLE;
          end
        end
        default: begin
          owner_q <= OWN_NONE;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
